// File: rtl/msu_pkg.sv
// Shared constants and state encoding for the
// redundant-to-binary converter.
package msu_pkg;

  localparam int MOD_LEN            = 1024;
  localparam int WORD_LEN           = 16;
  localparam int BIT_LEN            = 17;
  localparam int REDUNDANT_ELEMENTS = 2;
  localparam int NUM_ELEMENTS       =
    MOD_LEN / WORD_LEN + REDUNDANT_ELEMENTS;
  // coeff + carry fits in BIT_LEN+2 bits
  localparam int CARRY_LEN = BIT_LEN + 2 - WORD_LEN;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    HOLD
  } state_t;

endpackage

// File: rtl/redundant_to_binary_if.sv
// Handshake bundle between the squaring unit,
// the converter and the result consumer.
interface redundant_to_binary_if
  import msu_pkg::*;
#(
  parameter int NUM_ELEMENTS = msu_pkg::NUM_ELEMENTS,
  parameter int WORD_LEN     = msu_pkg::WORD_LEN
);

  logic                             in_valid;
  logic [NUM_ELEMENTS*2*WORD_LEN-1:0] sq_in;
  logic [NUM_ELEMENTS*WORD_LEN-1:0] bin_out;
  logic                             overflow;
  logic                             out_valid;
  logic                             out_ready;
  logic                             busy;
  logic [15:0]                      drop_cnt;

  modport master (
    output in_valid, sq_in, out_ready,
    input  bin_out, overflow, out_valid,
    input  busy, drop_cnt
  );

  modport slave (
    input  in_valid, sq_in, out_ready,
    output bin_out, overflow, out_valid,
    output busy, drop_cnt
  );

endinterface

// File: rtl/redundant_to_binary_carry_step.sv
// One carry-propagate step: redundant coefficient
// plus incoming carry -> binary word and carry out.
module carry_step
  import msu_pkg::*;
(
  input  logic [BIT_LEN-1:0]   i_coeff,
  input  logic [CARRY_LEN-1:0] i_carry,
  output logic [WORD_LEN-1:0]  o_word,
  output logic [CARRY_LEN-1:0] o_carry
);

  logic [BIT_LEN+1:0] w_acc;

  // widen both operands so the sum never wraps
  always_comb begin
    w_acc = {2'b00, i_coeff}
          + {{(BIT_LEN+2-CARRY_LEN){1'b0}}, i_carry};
    o_word  = w_acc[WORD_LEN-1:0];
    o_carry = w_acc[BIT_LEN+1:WORD_LEN];
  end

endmodule

// File: rtl/redundant_to_binary.sv
// Serial carry resolution of a redundant polynomial
// into canonical binary, one coefficient per cycle.
module redundant_to_binary
  import msu_pkg::*;
#(
  parameter int MOD_LEN            = 1024,
  parameter int WORD_LEN           = msu_pkg::WORD_LEN,
  parameter int REDUNDANT_ELEMENTS =
    msu_pkg::REDUNDANT_ELEMENTS,
  parameter int NUM_ELEMENTS       =
    MOD_LEN / WORD_LEN + REDUNDANT_ELEMENTS
)(
  input logic                  clk,
  input logic                  reset_n,
  redundant_to_binary_if.slave bus
);

  localparam int IW = $clog2(NUM_ELEMENTS + 1);
  localparam int LW = 2 * WORD_LEN;
  localparam int NB = NUM_ELEMENTS * WORD_LEN;

  state_t r_state;
  state_t w_next;

  logic [IW-1:0]        r_idx;
  logic [CARRY_LEN-1:0] r_carry;
  logic [BIT_LEN-1:0]   r_coeff [NUM_ELEMENTS];
  logic [WORD_LEN-1:0]  r_work  [NUM_ELEMENTS];
  logic [NB-1:0]        r_bin;
  logic                 r_ovf;
  logic [15:0]          r_drop;

  logic                 w_start;
  logic                 w_last;
  logic                 w_step;
  logic [BIT_LEN-1:0]   w_coeff;
  logic [WORD_LEN-1:0]  w_word;
  logic [CARRY_LEN-1:0] w_carry;
  logic [NB-1:0]        w_work_flat;
  logic                 w_unused_hi;

  assign w_start = (r_state == IDLE) && bus.in_valid;
  assign w_last  = (r_idx == IW'(NUM_ELEMENTS));
  assign w_step  = (r_state == CONVERT) && !w_last;
  assign w_coeff = w_last ? '0 : r_coeff[r_idx];

  carry_step u_step (
    .i_coeff (w_coeff),
    .i_carry (r_carry),
    .o_word  (w_word),
    .o_carry (w_carry)
  );

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // next state; extra CONVERT cycle at idx==N commits
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.in_valid)  w_next = CONVERT;
      CONVERT: if (w_last)        w_next = HOLD;
      HOLD:    if (bus.out_ready) w_next = IDLE;
      default:                    w_next = IDLE;
    endcase
  end

  // index, carry, published result and drop counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx   <= '0;
      r_carry <= '0;
      r_bin   <= '0;
      r_ovf   <= 1'b0;
      r_drop  <= '0;
    end else begin
      if (w_start) begin
        r_idx   <= '0;
        r_carry <= '0;
      end else if (w_step) begin
        r_idx   <= r_idx + IW'(1);
        r_carry <= w_carry;
      end
      if ((r_state == CONVERT) && w_last) begin
        r_bin <= w_work_flat;
        r_ovf <= (r_carry != '0);
      end
      if ((r_state != IDLE) && bus.in_valid
          && (r_drop != 16'hFFFF))
        r_drop <= r_drop + 16'd1;
    end
  end

  // working coefficient and word storage
  always_ff @(posedge clk) begin
    if (w_start) begin
      for (int j = 0; j < NUM_ELEMENTS; j++)
        r_coeff[j] <= bus.sq_in[j*LW +: BIT_LEN];
    end
    if (w_step) r_work[r_idx] <= w_word;
  end

  // flatten working words for the commit
  always_comb begin
    w_work_flat = '0;
    for (int j = 0; j < NUM_ELEMENTS; j++)
      w_work_flat[j*WORD_LEN +: WORD_LEN] = r_work[j];
  end

  // upper lane bits carry no information
  always_comb begin
    w_unused_hi = 1'b0;
    for (int j = 0; j < NUM_ELEMENTS; j++)
      w_unused_hi ^= ^bus.sq_in[j*LW+BIT_LEN +: LW-BIT_LEN];
  end

  assign bus.bin_out   = r_bin;
  assign bus.overflow  = r_ovf;
  assign bus.out_valid = (r_state == HOLD);
  assign bus.busy      = (r_state != IDLE);
  assign bus.drop_cnt  = r_drop;

endmodule

// File: tb/tb_redundant_to_binary.sv
// Scoreboard bench: stimulus pushes expected results,
// a negedge monitor pops and compares on handshake.
module tb_redundant_to_binary;

  localparam int NE = 66;
  localparam int WL = 16;
  localparam int NB = NE * WL;
  localparam int NRAND = 1000;

  typedef struct packed {
    logic [NB-1:0] bin;
    logic          ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rdy_mode = 0;

  exp_t          exp_q [$];
  logic [16:0]   stim_c [NE];

  redundant_to_binary_if #(
    .NUM_ELEMENTS(NE), .WORD_LEN(WL)
  ) bus ();

  redundant_to_binary dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #950000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm,
                     input longint got,
                     input longint want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, got, want);
    end
  endtask

  // consumer ready pattern
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready =
                   ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // monitor: compare each accepted result
  initial begin
    exp_t e;
    int   k;
    forever begin
      @(negedge clk);
      if (reset_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got 1 want 0");
        end else begin
          e = exp_q.pop_front();
          n_cmp++;
          if (bus.bin_out != e.bin) begin
            n_bad++;
            k = 0;
            while (k < NE - 1 && bus.bin_out[k*WL +: WL]
                   == e.bin[k*WL +: WL]) k++;
            $display("FAIL bin_out word %0d: got %h want %h",
                     k, bus.bin_out[k*WL +: WL],
                     e.bin[k*WL +: WL]);
          end
          chk("overflow", bus.overflow, e.ovf);
        end
      end
    end
  end

  function automatic exp_t model();
    logic [NB+15:0] s;
    logic [NB+15:0] t;
    exp_t r;
    s = '0;
    for (int j = 0; j < NE; j++) begin
      t = '0;
      t[16:0] = stim_c[j];
      s = s + (t << (WL * j));
    end
    r.bin = s[NB-1:0];
    r.ovf = (s[NB+15:NB] != '0);
    return r;
  endfunction

  // aligned at posedge+1 on entry and exit
  task automatic send(input bit use_model,
                      input logic [NB-1:0] hb,
                      input logic ho,
                      output int t0);
    int   n;
    logic [31:0] rnd;
    exp_t e;
    n = 0;
    while (bus.busy && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 400) chk("send_idle_wait", 1, 0);
    for (int j = 0; j < NE; j++) begin
      rnd = $urandom();
      bus.sq_in[j*32 +: 32] = {rnd[31:17], stim_c[j]};
    end
    if (use_model) e = model();
    else begin
      e.bin = hb;
      e.ovf = ho;
    end
    exp_q.push_back(e);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_in();
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  initial begin
    logic [NB-1:0] hb;
    int t0;
    int n;

    bus.in_valid = 1'b0;
    bus.sq_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_bin_out", (bus.bin_out != '0), 0);
    chk("rst_drop_cnt", bus.drop_cnt, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // all zero, plus latency
    for (int j = 0; j < NE; j++) stim_c[j] = 17'h0;
    send(1'b0, '0, 1'b0, t0);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("latency", cyc - t0, 67);
    @(posedge clk);
    #1;
    drain("drain_zero");

    // carry across two words
    for (int j = 0; j < NE; j++) stim_c[j] = 17'h0;
    stim_c[0] = 17'h1FFFF;
    stim_c[1] = 17'h0FFFF;
    hb = '0;
    hb[47:0] = 48'h0001_0000_FFFF;
    send(1'b0, hb, 1'b0, t0);
    drain("drain_two");

    // all max: overflow, steady carry of 2
    for (int j = 0; j < NE; j++) stim_c[j] = 17'h1FFFF;
    hb = '0;
    hb[15:0] = 16'hFFFF;
    for (int j = 2; j < NE; j++) hb[j*WL +: WL] = 16'h0001;
    send(1'b0, hb, 1'b1, t0);
    drain("drain_max");

    // drops during CONVERT and HOLD
    for (int j = 0; j < NE; j++) stim_c[j] = 17'h10000;
    hb = '0;
    for (int j = 1; j < NE; j++) hb[j*WL +: WL] = 16'h0001;
    rdy_mode = 2;
    send(1'b0, hb, 1'b1, t0);
    repeat (9) @(posedge clk);
    #1;
    for (int j = 0; j < NE; j++) bus.sq_in[j*32 +: 32] = 32'h1;
    pulse_in();
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("hold_reached", bus.out_valid, 1);
    pulse_in();
    chk("drop_cnt_2", bus.drop_cnt, 2);
    chk("hold_kept", bus.out_valid, 1);
    // in_valid together with the handshake
    #1;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("drop_cnt_3", bus.drop_cnt, 3);
    chk("idle_after_hs", bus.busy, 0);
    drain("drain_drop");

    // reset in the middle of CONVERT
    for (int j = 0; j < NE; j++) stim_c[j] = 17'h1FFFF;
    send(1'b1, '0, 1'b0, t0);
    repeat (29) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_drop_cnt", bus.drop_cnt, 0);
    chk("mid_rst_bin_out", (bus.bin_out != '0), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int j = 0; j < NE; j++) stim_c[j] = 17'h0;
    stim_c[0] = 17'h1FFFF;
    stim_c[1] = 17'h0FFFF;
    hb = '0;
    hb[47:0] = 48'h0001_0000_FFFF;
    send(1'b0, hb, 1'b0, t0);
    drain("drain_post_rst");

    // random vectors with backpressure
    rdy_mode = 1;
    for (int v = 0; v < NRAND; v++) begin
      for (int j = 0; j < NE; j++) begin
        if ($urandom_range(0, 3) == 0)
          stim_c[j] = 17'h1FFFF;
        else
          stim_c[j] = 17'($urandom());
      end
      send(1'b1, '0, 1'b0, t0);
    end
    drain("drain_rand");
    chk("final_drop_cnt", bus.drop_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
